// File: rtl/multicycle_controller.sv
// Multicycle ARM controller: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB over a shared
// memory/ALU datapath, with NZCV flag register and a condition-pass bit latched in DECODE.
// Control outputs are registered from the next state; write strobes are gated by reset.
module multicycle_controller #(
  parameter int unsigned ALUCTRL_W = 2,
  parameter int unsigned STATE_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           Flags,
  output logic [STATE_W-1:0]   State
);

  typedef enum logic [STATE_W-1:0] {
    StFetch  = STATE_W'(0),
    StDecode = STATE_W'(1),
    StMemAdr = STATE_W'(2),
    StMemRd  = STATE_W'(3),
    StMemWb  = STATE_W'(4),
    StMemWr  = STATE_W'(5),
    StExecR  = STATE_W'(6),
    StExecI  = STATE_W'(7),
    StAluWb  = STATE_W'(8),
    StBranch = STATE_W'(9)
  } state_e;

  typedef struct packed {
    logic                 pc_write;
    logic                 adr_src;
    logic                 mem_write;
    logic                 ir_write;
    logic                 reg_write;
    logic [1:0]           result_src;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [ALUCTRL_W-1:0] alu_control;
  } ctrl_t;

  localparam logic [ALUCTRL_W-1:0] AluAdd = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] AluSub = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] AluAnd = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] AluOrr = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] AluEor = ALUCTRL_W'(4);

  // Instr carries bits [31:12] of the instruction word, so field indices are shifted by 12.
  logic [3:0] cond;
  logic [1:0] op;
  logic       imm_bit;
  logic [3:0] cmd;
  logic       s_l_bit;
  logic [3:0] rd;
  logic       unused_instr;

  assign cond         = Instr[19:16];
  assign op           = Instr[15:14];
  assign imm_bit      = Instr[13];
  assign cmd          = Instr[12:9];
  assign s_l_bit      = Instr[8];
  assign rd           = Instr[3:0];
  assign unused_instr = ^Instr[7:4];

  state_e state_q, state_d;
  logic [3:0] flags_q;
  logic       condexr_q, condexr_d;
  ctrl_t      ctrl_q, ctrl_d, fetch_ctrl;

  logic                 cond_ex;
  logic [ALUCTRL_W-1:0] dp_alu;
  logic                 dp_nowrite;
  logic                 dp_s;
  logic                 dp_cv;

  // Moore output table; cex is the condition-pass bit valid during the target state.
  function automatic ctrl_t state_outputs(input state_e st, input logic cex,
                                          input logic nowrite, input logic rd_pc,
                                          input logic [ALUCTRL_W-1:0] alu);
    ctrl_t c;
    c             = '0;
    c.alu_control = AluAdd;
    case (st)
      StFetch: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.ir_write   = 1'b1;
        c.pc_write   = 1'b1;
      end
      StDecode: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      StMemAdr: c.alu_src_b = 2'b01;
      StMemRd:  c.adr_src   = 1'b1;
      StMemWr: begin
        c.adr_src   = 1'b1;
        c.mem_write = cex;
      end
      StMemWb: begin
        c.result_src = 2'b01;
        c.reg_write  = cex;
      end
      StExecR: c.alu_control = alu;
      StExecI: begin
        c.alu_src_b   = 2'b01;
        c.alu_control = alu;
      end
      StAluWb: begin
        c.reg_write = cex & ~nowrite;
        c.pc_write  = cex & rd_pc & ~nowrite;
      end
      StBranch: begin
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.pc_write   = cex;
      end
      default: ;
    endcase
    return c;
  endfunction

  // Data-processing decode: ALU code, write suppression, effective S and carry/overflow update.
  always_comb begin
    dp_alu     = AluAdd;
    dp_nowrite = 1'b1;
    dp_s       = 1'b0;
    dp_cv      = 1'b0;
    case (cmd)
      4'b0100: begin
        dp_alu = AluAdd; dp_nowrite = 1'b0; dp_s = s_l_bit; dp_cv = 1'b1;
      end
      4'b0010: begin
        dp_alu = AluSub; dp_nowrite = 1'b0; dp_s = s_l_bit; dp_cv = 1'b1;
      end
      4'b0000: begin
        dp_alu = AluAnd; dp_nowrite = 1'b0; dp_s = s_l_bit;
      end
      4'b1100: begin
        dp_alu = AluOrr; dp_nowrite = 1'b0; dp_s = s_l_bit;
      end
      4'b0001: begin
        if (ALUCTRL_W >= 3) begin
          dp_alu = AluEor; dp_nowrite = 1'b0; dp_s = s_l_bit;
        end
      end
      4'b1010: begin
        // CMP: subtract, always sets flags, never writes a register.
        if (ALUCTRL_W >= 3) begin
          dp_alu = AluSub; dp_nowrite = 1'b1; dp_s = 1'b1; dp_cv = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ARM condition evaluation against the architectural flags {N,Z,C,V}.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~(flags_q[1] & ~flags_q[2]);
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Next-state sequencing; illegal encodings fall back to FETCH.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          2'b01:   state_d = StMemAdr;
          2'b00:   state_d = imm_bit ? StExecI : StExecR;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = s_l_bit ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StExecR:  state_d = StAluWb;
      StExecI:  state_d = StAluWb;
      default:  state_d = StFetch;
    endcase
  end

  // Condition bit is captured only in DECODE; outputs are precomputed for the next state.
  always_comb begin
    condexr_d  = (state_q == StDecode) ? cond_ex : condexr_q;
    ctrl_d     = state_outputs(state_d, condexr_d, dp_nowrite, (rd == 4'hf), dp_alu);
    fetch_ctrl = state_outputs(StFetch, 1'b0, 1'b0, 1'b0, AluAdd);
  end

  // State, condition bit, flags and registered control outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      flags_q   <= 4'b0000;
      condexr_q <= 1'b0;
      ctrl_q    <= fetch_ctrl;
    end else begin
      state_q   <= state_d;
      condexr_q <= condexr_d;
      ctrl_q    <= ctrl_d;
      if ((state_q == StExecR || state_q == StExecI) && condexr_q && dp_s) begin
        flags_q[3:2] <= ALUFlags[3:2];
        if (dp_cv) begin
          flags_q[1:0] <= ALUFlags[1:0];
        end
      end
    end
  end

  // Strobes are held low and mux selects follow FETCH for as long as reset is asserted.
  assign PCWrite    = reset & ctrl_q.pc_write;
  assign IRWrite    = reset & ctrl_q.ir_write;
  assign MemWrite   = reset & ctrl_q.mem_write;
  assign RegWrite   = reset & ctrl_q.reg_write;
  assign AdrSrc     = reset ? ctrl_q.adr_src     : fetch_ctrl.adr_src;
  assign ResultSrc  = reset ? ctrl_q.result_src  : fetch_ctrl.result_src;
  assign ALUSrcA    = reset ? ctrl_q.alu_src_a   : fetch_ctrl.alu_src_a;
  assign ALUSrcB    = reset ? ctrl_q.alu_src_b   : fetch_ctrl.alu_src_b;
  assign ALUControl = reset ? ctrl_q.alu_control : fetch_ctrl.alu_control;

  assign ImmSrc = op;
  assign RegSrc = {(op == 2'b01), (op == 2'b10)};
  assign Flags  = flags_q;
  assign State  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a 3-bit ALUControl instance (EOR/CMP enabled) and a
// 2-bit instance share the same stimulus so CMP handling can be compared between the two.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] Flags, State;

  logic       n_PCWrite, n_AdrSrc, n_MemWrite, n_IRWrite, n_RegWrite, n_ALUSrcA;
  logic [1:0] n_ResultSrc, n_ALUSrcB, n_ImmSrc, n_RegSrc;
  logic [1:0] n_ALUControl;
  logic [3:0] n_Flags, n_State;

  int checks;
  int failures;

  multicycle_controller #(.ALUCTRL_W(3), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .Flags(Flags), .State(State)
  );

  multicycle_controller #(.ALUCTRL_W(2), .STATE_W(4)) dut2 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(n_PCWrite), .AdrSrc(n_AdrSrc), .MemWrite(n_MemWrite), .IRWrite(n_IRWrite),
    .RegWrite(n_RegWrite), .ResultSrc(n_ResultSrc), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB),
    .ImmSrc(n_ImmSrc), .RegSrc(n_RegSrc), .ALUControl(n_ALUControl), .Flags(n_Flags),
    .State(n_State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; Instr = 20'h0; ALUFlags = 4'h0;
    #1;
    checks++; if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin failures++;
      $display("FAIL rst_strobes_t0 got=%b exp=0000", {PCWrite, IRWrite, MemWrite, RegWrite}); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (State !== 4'd0) begin failures++;
        $display("FAIL rst_state got=%0d exp=0", State); end
      checks++; if (Flags !== 4'b0000) begin failures++;
        $display("FAIL rst_flags got=%b exp=0000", Flags); end
      checks++; if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin failures++;
        $display("FAIL rst_strobes got=%b exp=0000", {PCWrite, IRWrite, MemWrite, RegWrite}); end
      checks++; if ({ALUSrcA, ALUSrcB, ResultSrc} !== 5'b11010) begin failures++;
        $display("FAIL rst_muxes got=%b exp=11010", {ALUSrcA, ALUSrcB, ResultSrc}); end
    end
    reset = 1'b1;
    #1;
    checks++; if ({PCWrite, IRWrite} !== 2'b11) begin failures++;
      $display("FAIL fetch_strobes got=%b exp=11", {PCWrite, IRWrite}); end
  endtask

  task automatic test_adds();
    Instr = 20'hE0911; ALUFlags = 4'b0000;
    tick();
    checks++; if (State !== 4'd1) begin failures++;
      $display("FAIL adds_decode got=%0d exp=1", State); end
    checks++; if ({PCWrite, IRWrite} !== 2'b00) begin failures++;
      $display("FAIL adds_decode_strobes got=%b exp=00", {PCWrite, IRWrite}); end
    tick();
    checks++; if (State !== 4'd6) begin failures++;
      $display("FAIL adds_execr got=%0d exp=6", State); end
    checks++; if ({ALUSrcA, ALUSrcB, ALUControl} !== 6'b000000) begin failures++;
      $display("FAIL adds_execr_ctl got=%b exp=000000", {ALUSrcA, ALUSrcB, ALUControl}); end
    ALUFlags = 4'b0110;
    tick();
    ALUFlags = 4'b0000;
    checks++; if (State !== 4'd8) begin failures++;
      $display("FAIL adds_aluwb got=%0d exp=8", State); end
    checks++; if (RegWrite !== 1'b1 || PCWrite !== 1'b0) begin failures++;
      $display("FAIL adds_regwrite got=%b%b exp=10", RegWrite, PCWrite); end
    checks++; if (Flags !== 4'b0110) begin failures++;
      $display("FAIL adds_flags got=%b exp=0110", Flags); end
    checks++; if (n_Flags !== 4'b0110) begin failures++;
      $display("FAIL adds_flags_w2 got=%b exp=0110", n_Flags); end
    tick();
    checks++; if (State !== 4'd0 || RegWrite !== 1'b0) begin failures++;
      $display("FAIL adds_done got=%0d/%b exp=0/0", State, RegWrite); end
  endtask

  task automatic test_ldr_str();
    logic [3:0] exp_ldr [5];
    logic [3:0] exp_str [4];
    exp_ldr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    exp_str = '{4'd0, 4'd1, 4'd2, 4'd5};
    Instr = 20'hE5912;
    for (int i = 0; i < 5; i++) begin
      checks++; if (State !== exp_ldr[i] || RegWrite !== (i == 4)) begin failures++;
        $display("FAIL ldr_step%0d got=%0d/%b exp=%0d/%b", i, State, RegWrite, exp_ldr[i],
                 (i == 4)); end
      if (i == 1) begin
        checks++; if (ImmSrc !== 2'b01 || RegSrc !== 2'b10) begin failures++;
          $display("FAIL ldr_imm_regsrc got=%b/%b exp=01/10", ImmSrc, RegSrc); end
      end
      tick();
    end
    Instr = 20'hE5812;
    for (int i = 0; i < 4; i++) begin
      checks++; if (State !== exp_str[i] || MemWrite !== (i == 3)) begin failures++;
        $display("FAIL str_step%0d got=%0d/%b exp=%0d/%b", i, State, MemWrite, exp_str[i],
                 (i == 3)); end
      tick();
    end
    checks++; if (State !== 4'd0 || MemWrite !== 1'b0) begin failures++;
      $display("FAIL str_done got=%0d/%b exp=0/0", State, MemWrite); end
  endtask

  task automatic test_branch();
    Instr = 20'h0A000;
    tick(); tick();
    checks++; if (State !== 4'd9 || PCWrite !== 1'b1) begin failures++;
      $display("FAIL beq_taken got=%0d/%b exp=9/1", State, PCWrite); end
    tick();
    checks++; if (State !== 4'd0) begin failures++;
      $display("FAIL beq_len got=%0d exp=0", State); end
    Instr = 20'h1A000;
    tick(); tick();
    checks++; if (State !== 4'd9 || PCWrite !== 1'b0) begin failures++;
      $display("FAIL bne_not_taken got=%0d/%b exp=9/0", State, PCWrite); end
    tick();
    checks++; if (State !== 4'd0) begin failures++;
      $display("FAIL bne_len got=%0d exp=0", State); end
  endtask

  task automatic test_cmp();
    Instr = 20'hE3501;
    tick(); tick();
    checks++; if (State !== 4'd7 || ALUControl !== 3'b001) begin failures++;
      $display("FAIL cmp_execi got=%0d/%b exp=7/001", State, ALUControl); end
    checks++; if (n_ALUControl !== 2'b00) begin failures++;
      $display("FAIL cmp_w2_alu got=%b exp=00", n_ALUControl); end
    ALUFlags = 4'b0100;
    tick();
    ALUFlags = 4'b0000;
    checks++; if (Flags !== 4'b0100 || RegWrite !== 1'b0) begin failures++;
      $display("FAIL cmp_flags got=%b/%b exp=0100/0", Flags, RegWrite); end
    checks++; if (n_Flags !== 4'b0110 || n_RegWrite !== 1'b0) begin failures++;
      $display("FAIL cmp_w2_flags got=%b/%b exp=0110/0", n_Flags, n_RegWrite); end
    tick();
    checks++; if (State !== 4'd0) begin failures++;
      $display("FAIL cmp_done got=%0d exp=0", State); end
  endtask

  task automatic test_midreset_undef();
    Instr = 20'hE5912;
    tick(); tick(); tick();
    checks++; if (State !== 4'd3) begin failures++;
      $display("FAIL mid_memrd got=%0d exp=3", State); end
    reset = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0) begin failures++;
      $display("FAIL mid_regwrite got=%b exp=0", RegWrite); end
    tick();
    checks++; if (State !== 4'd0 || RegWrite !== 1'b0 || Flags !== 4'b0000) begin failures++;
      $display("FAIL mid_reset got=%0d/%b/%b exp=0/0/0000", State, RegWrite, Flags); end
    reset = 1'b1;
    Instr = 20'hEC000;
    #1;
    tick();
    checks++; if (State !== 4'd1) begin failures++;
      $display("FAIL undef_decode got=%0d exp=1", State); end
    tick();
    checks++; if (State !== 4'd0 || {PCWrite, IRWrite} !== 2'b11) begin failures++;
      $display("FAIL undef_fetch got=%0d/%b exp=0/11", State, {PCWrite, IRWrite}); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_adds();
    test_ldr_str();
    test_branch();
    test_cmp();
    test_midreset_undef();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
